// File: rtl/c2c_pkg.sv
// Shared definitions for the board-to-board link: handshake state encoding
// and default sizing for data width and notice hold time.
package c2c_pkg;

    localparam int DATA_W_DEF        = 3;
    localparam int NOTICE_CYCLES_DEF = 100_000_000;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        WAIT_ACK   = 2'b01,
        DATA_VALID = 2'b10,
        DONE       = 2'b11
    } c2c_state_e;

endpackage

// File: rtl/master_notice_timer.sv
// Retriggerable hold timer: active goes high on start and stays high for
// exactly CYCLES clocks. Shared by both ends of the link.
module master_notice_timer
    import c2c_pkg::*;
#(
    parameter int CYCLES = NOTICE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic active
);

    localparam int            CW   = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q;

    // Down-counter parks at zero rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= (cnt_d != '0);
        end
    end

    assign active = active_q;

endmodule

// File: rtl/master_control.sv
// Sending-side four-phase handshake controller (request/ack, valid/ack).
// Define MASTER_ACK_SYNC_EN to pass ack through a 2-flop synchroniser.
//
// state      | meaning
// IDLE       | waiting for a send pulse
// WAIT_ACK   | request high, waiting for ack to rise
// DATA_VALID | valid high, data held, waiting for ack to fall
// DONE       | one-cycle completion pulse
module master_control
    import c2c_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int NOTICE_CYCLES = NOTICE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              send,
    input  logic [DATA_W-1:0] data_sw,
    input  logic              ack,
    output logic              request,
    output logic              valid,
    output logic [DATA_W-1:0] data_out,
    output logic              notice,
    output logic              busy,
    output logic              done
);

    c2c_state_e        state_q;
    logic              request_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              busy_q;
    logic              done_q;
    logic              ack_s;
    logic              accept;

`ifdef MASTER_ACK_SYNC_EN
    logic [1:0] ack_sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[0], ack};
        end
    end

    assign ack_s = ack_sync_q[1];
`else
    assign ack_s = ack;
`endif

    assign accept = (state_q == IDLE) && send;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            request_q <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (send) begin
                        data_q    <= data_sw;
                        request_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_s) begin
                        request_q <= 1'b0;
                        valid_q   <= 1'b1;
                        state_q   <= DATA_VALID;
                    end
                end
                DATA_VALID: begin
                    if (!ack_s) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    master_notice_timer #(
        .CYCLES (NOTICE_CYCLES)
    ) u_notice (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept),
        .active (notice)
    );

    assign request  = request_q;
    assign valid    = valid_q;
    assign data_out = data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
